// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: broadcast payload, requester index constants and a liveness helper.
package cdb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] cdb_data;
    logic [5:0]  cdb_tag;
    logic        cdb_valid;
    logic        cdb_branch;
    logic        cdb_branch_taken;
  } cdb_bus;

  localparam int CDB_REQ_INT = 0;
  localparam int CDB_REQ_MEM = 1;
  localparam int CDB_REQ_MUL = 2;
  localparam int CDB_REQ_DIV = 3;

  // An entry with neither flag set carries nothing worth broadcasting.
  function automatic logic cdb_is_live(input cdb_bus b);
    return b.cdb_valid | b.cdb_branch;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Execution-unit side of the CDB arbiter: per-requester valid/ready inputs, flush and the broadcast.
// A transfer on requester i happens on a rising edge where in_valid[i] and in_ready[i] are both high.
interface cdb_arbiter_if #(parameter int N_REQ = 4);
  import cdb_arbiter_pkg::*;

  logic   [N_REQ-1:0] in_valid;
  cdb_bus [N_REQ-1:0] in_bus;
  logic   [N_REQ-1:0] in_ready;
  logic               flush;
  cdb_bus             cdb_out;
  logic   [N_REQ-1:0] cdb_grant;

  modport master (
    output in_valid, in_bus, flush,
    input  in_ready, cdb_out, cdb_grant
  );

  modport slave (
    input  in_valid, in_bus, flush,
    output in_ready, cdb_out, cdb_grant
  );

endinterface

// File: rtl/cdb_arbiter_pick.sv
// cdb_pick: combinational one-hot grant over req; fixed priority by default,
// rotate-priority-rotate starting at ptr when CDB_ARB_RR_EN is defined.
module cdb_pick #(
  parameter  int N_REQ = 4,
  localparam int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_idx
);

`ifdef CDB_ARB_RR_EN
  logic [N_REQ-1:0] w_rot;
  logic [PW-1:0]    w_off;
  logic [PW:0]      w_sum;

  // Rotate so that ptr lands at bit 0, pick the lowest, then rotate the index back.
  assign w_rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_off     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = PW'(k);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (PW+1)'(N_REQ)) w_sum = w_sum - (PW+1)'(N_REQ);
    if (|w_rot) begin
      grant_idx        = w_sum[PW-1:0];
      grant[grant_idx] = 1'b1;
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one-entry buffer per execution unit, one registered broadcast per cycle.
// Define CDB_ARB_RR_EN for round-robin arbitration; default is fixed priority (index 0 first).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic   [N_REQ-1:0] r_full;
  cdb_bus [N_REQ-1:0] r_buf;
  cdb_bus             r_cdb_out;
  logic   [N_REQ-1:0] r_cdb_grant;

  logic [N_REQ-1:0] w_req;
  logic [N_REQ-1:0] w_null;
  logic [N_REQ-1:0] w_grant;
  logic [N_REQ-1:0] w_in_ready;
  logic [N_REQ-1:0] w_accept;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ptr;
  logic             w_any;

  always_comb begin
    w_req  = '0;
    w_null = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_req[i]  = r_full[i] &  cdb_is_live(r_buf[i]);
      w_null[i] = r_full[i] & ~cdb_is_live(r_buf[i]);
    end
  end

  // A granted buffer drains this edge, so it may take a new entry at the same time.
  assign w_in_ready = {N_REQ{~rst & ~bus.flush}} & (~r_full | w_grant);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_any      = |w_grant;

  cdb_pick #(.N_REQ(N_REQ)) u_pick (
    .req       (w_req),
    .ptr       (w_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= '0;
      r_buf       <= '0;
      r_cdb_out   <= '0;
      r_cdb_grant <= '0;
    end else if (bus.flush) begin
      r_full      <= '0;
      r_cdb_out   <= '0;
      r_cdb_grant <= '0;
    end else begin
      r_cdb_out   <= w_any ? r_buf[w_gidx] : '0;
      r_cdb_grant <= w_grant;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_accept[i]) begin
          r_full[i] <= 1'b1;
          r_buf[i]  <= bus.in_bus[i];
        end else if (w_grant[i] | w_null[i]) begin
          r_full[i] <= 1'b0;
        end
      end
    end
  end

`ifdef CDB_ARB_RR_EN
  logic [PW-1:0] r_ptr;

  // Pointer survives flush so a recovering core does not bias back to the integer unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (!bus.flush && w_any) begin
      r_ptr <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.cdb_out   = r_cdb_out;
  assign bus.cdb_grant = r_cdb_grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic checked against a slot-level model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = N + $bits(cdb_bus);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.N_REQ(N)) bus ();

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [W-1:0] exp_q[$];

  // Model: each requester owns one slot; the bus takes one live slot per cycle.
  logic   m_full[N];
  cdb_bus m_buf[N];
  int     m_ptr;

  logic [N-1:0] drv_valid;
  cdb_bus       drv_bus[N];
  logic         drv_flush;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic cdb_bus mk(input logic [31:0] d, input logic [5:0] t,
                                input logic v, input logic b, input logic tk);
    cdb_bus r;
    r.cdb_data         = d;
    r.cdb_tag          = t;
    r.cdb_valid        = v;
    r.cdb_branch       = b;
    r.cdb_branch_taken = tk;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_full[i] = 1'b0;
      m_buf[i]  = '0;
    end
    m_ptr = 0;
    exp_q.delete();
  endtask

  task automatic drive_idle();
    drv_valid = '0;
    drv_flush = 1'b0;
    for (int i = 0; i < N; i++) drv_bus[i] = '0;
  endtask

  // Called at a falling edge: drive, check ready, advance model, check the broadcast.
  task automatic step();
    int           g;
    logic [N-1:0] exp_rdy;
    logic         live[N];
    logic [N-1:0] oh;
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) begin
      bus.in_valid[i] = drv_valid[i];
      bus.in_bus[i]   = drv_bus[i];
    end
    bus.flush = drv_flush;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      live[idx] = m_buf[idx].cdb_valid || m_buf[idx].cdb_branch;
      if (g < 0 && m_full[idx] && live[idx]) g = idx;
    end
    for (int i = 0; i < N; i++) exp_rdy[i] = !drv_flush && (!m_full[i] || g == i);
    check_eq("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (drv_flush) begin
      exp_q.push_back('0);
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
    end else begin
      if (g >= 0) begin
        oh    = '0;
        oh[g] = 1'b1;
        exp_q.push_back({oh, m_buf[g]});
`ifdef CDB_ARB_RR_EN
        m_ptr = (g + 1) % N;
`endif
      end else begin
        exp_q.push_back('0);
      end
      for (int i = 0; i < N; i++) begin
        if (drv_valid[i] && exp_rdy[i]) begin
          m_full[i] = 1'b1;
          m_buf[i]  = drv_bus[i];
        end else if (g == i || (m_full[i] && !live[i])) begin
          m_full[i] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("cdb_out", 64'({bus.cdb_grant, bus.cdb_out}), 64'(e));
    end
  endtask

  initial begin
    drive_idle();
    bus.in_valid = '0;
    bus.in_bus   = '0;
    bus.flush    = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(bus.in_ready), 64'd0);
    check_eq("rst_out", 64'(bus.cdb_out), 64'd0);
    check_eq("rst_grant", 64'(bus.cdb_grant), 64'd0);
    rst = 1'b0;

    // Single integer result, latency and one-cycle pulse
    drv_valid[CDB_REQ_INT] = 1'b1;
    drv_bus[CDB_REQ_INT]   = mk(32'h0000_0005, 6'd3, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    check_eq("t1_data", 64'(bus.cdb_out.cdb_data), 64'h5);
    check_eq("t1_tag", 64'(bus.cdb_out.cdb_tag), 64'd3);
    check_eq("t1_grant", 64'(bus.cdb_grant), 64'b0001);
    step();
    check_eq("t1_pulse", 64'(bus.cdb_grant), 64'd0);

    // Integer and divide together: loser held and unchanged
    drv_valid = 4'b1001;
    drv_bus[CDB_REQ_INT] = mk(32'h1111_0000, 6'd10, 1'b1, 1'b0, 1'b0);
    drv_bus[CDB_REQ_DIV] = mk(32'hD1D1_D1D1, 6'd42, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    step();
`ifndef CDB_ARB_RR_EN
    check_eq("t2_div_data", 64'(bus.cdb_out.cdb_data), 64'hD1D1_D1D1);
    check_eq("t2_div_grant", 64'(bus.cdb_grant), 64'b1000);
`endif
    step();

    // Branch result
    drv_valid[CDB_REQ_INT] = 1'b1;
    drv_bus[CDB_REQ_INT]   = mk(32'h0, 6'd0, 1'b0, 1'b1, 1'b1);
    step();
    drive_idle();
    step();
    check_eq("t3_branch", 64'({bus.cdb_out.cdb_branch, bus.cdb_out.cdb_branch_taken,
                               bus.cdb_out.cdb_valid}), 64'b110);
    check_eq("t3_tag", 64'(bus.cdb_out.cdb_tag), 64'd0);
    step();

    // Back-to-back stream from the integer unit
    for (int t = 1; t <= 8; t++) begin
      drv_valid = 4'b0001;
      drv_bus[CDB_REQ_INT] = mk($urandom, 6'(t), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive_idle();
    repeat (2) step();

    // All four requesters continuously valid
    for (int t = 0; t < 12; t++) begin
      drv_valid = 4'b1111;
      for (int i = 0; i < N; i++) drv_bus[i] = mk($urandom, 6'(16 * i + t), 1'b1, 1'b0, 1'b0);
      step();
    end
    drive_idle();
    repeat (5) step();

    // Three buffers full, then flush with inputs still presented
    drv_valid = 4'b1011;
    for (int i = 0; i < N; i++) drv_bus[i] = mk($urandom, 6'(i + 50), 1'b1, 1'b0, 1'b0);
    step();
    drv_flush = 1'b1;
    step();
    check_eq("t6_flush_out", 64'({bus.cdb_grant, bus.cdb_out}), 64'd0);
    drive_idle();
    repeat (2) step();

    // Reset asserted while a result is on the bus
    drv_valid[CDB_REQ_MUL] = 1'b1;
    drv_bus[CDB_REQ_MUL]   = mk(32'hCAFE_F00D, 6'd7, 1'b1, 1'b0, 1'b0);
    step();
    drive_idle();
    step();
    rst = 1'b1;
    bus.in_valid = '0;
    #1;
    check_eq("t7_async_out", 64'({bus.cdb_grant, bus.cdb_out}), 64'd0);
    check_eq("t7_async_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random traffic including null entries and flushes
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        int sel;
        sel = $urandom_range(0, 9);
        drv_valid[i] = 1'($urandom_range(0, 1));
        drv_bus[i]   = mk($urandom, 6'($urandom_range(0, 63)),
                          (sel <= 5) || (sel == 8), (sel >= 6) && (sel <= 8),
                          1'($urandom_range(0, 1)));
      end
      drv_flush = ($urandom_range(0, 19) == 0);
      step();
    end
    drive_idle();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
